// File: rtl/mmio_uart_bridge_pkg.sv
// Shared constants, drain-FSM state type and LSR formatting for the MMIO UART bridge.
package mmio_uart_bridge_pkg;

    localparam logic [63:0] DEFAULT_UART_BASE = 64'h1000_0000;

    localparam logic [2:0] THR_LANE = 3'd0;
    localparam logic [2:0] RBR_LANE = 3'd0;
    localparam logic [2:0] LSR_LANE = 3'd5;

    localparam int RBR_LSB = 8 * int'(RBR_LANE);
    localparam int LSR_LSB = 8 * int'(LSR_LANE);

    localparam int LSR_RDY  = 0;
    localparam int LSR_THRE = 5;
    localparam int LSR_OVF  = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } drain_state_t;

    // RX is always reported ready; unlisted bits read as zero.
    function automatic logic [7:0] lsr_byte(input logic overflow, input logic full);
        logic [7:0] v;
        v           = 8'h00;
        v[LSR_RDY]  = 1'b1;
        v[LSR_THRE] = ~full;
        v[LSR_OVF]  = overflow;
        return v;
    endfunction

endpackage

// File: rtl/mmio_uart_bridge_tx_fifo.sv
// Synchronous character FIFO; a push into a full FIFO is accepted when a pop happens the same cycle.
module mmio_uart_bridge_tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_push,
    input  logic [7:0] i_push_data,
    input  logic       i_pop,
    output logic [7:0] o_head,
    output logic       o_empty,
    output logic       o_full,
    output logic       o_dropped
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_dropped = i_push & ~w_do_push;
    assign o_head    = r_mem[r_rd_ptr];

    // NOTE: storage is not reset; entries are only read after a push has written them.
    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_bridge.sv
// UART responder on the MEM-stage data port: THR stores feed a TX FIFO drained onto io_uart_out_*,
// RBR/LSR loads return registered data one cycle later.
module mmio_uart_bridge
    import mmio_uart_bridge_pkg::*;
#(
    parameter logic [63:0] UART_BASE  = DEFAULT_UART_BASE,
    parameter int          FIFO_DEPTH = 8,
    parameter int          TX_GAP     = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_wen,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [63:0] req_wmask,
    output logic        hit,
    output logic [63:0] rsp_rdata,
    output logic        io_uart_out_valid,
    output logic [7:0]  io_uart_out_ch,
    output logic        io_uart_in_valid,
    input  logic [7:0]  io_uart_in_ch
);
    localparam int GAP_W = (TX_GAP > 1) ? $clog2(TX_GAP) : 1;

    logic [2:0]   w_lane;
    logic         w_hit;
    logic         w_load;
    logic         w_thr_write;
    logic         w_lsr_read;
    logic         w_empty;
    logic         w_full;
    logic         w_drop;
    logic         w_pop;
    logic         w_drain_ready;
    logic [7:0]   w_head;
    logic         w_unused;

    drain_state_t     r_state;
    logic [GAP_W-1:0] r_gap_cnt;
    logic             r_out_valid;
    logic [7:0]       r_out_ch;
    logic             r_overflow;
    logic [63:0]      r_rsp_rdata;

    assign w_lane      = req_addr[2:0];
    assign w_hit       = req_valid & (req_addr[63:3] == UART_BASE[63:3]);
    assign w_load      = w_hit & ~req_wen;
    assign w_thr_write = w_hit & req_wen & (w_lane == THR_LANE) & (req_wmask[7:0] == 8'hFF);
    assign w_lsr_read  = w_load & (w_lane == LSR_LANE);
    // Only the low byte lane of data and mask matters to this device.
    assign w_unused    = ^{req_wdata[63:8], req_wmask[63:8]};

    assign hit               = w_hit;
    assign io_uart_in_valid  = w_load & (w_lane == RBR_LANE);
    assign rsp_rdata         = r_rsp_rdata;
    assign io_uart_out_valid = r_out_valid;
    assign io_uart_out_ch    = r_out_ch;

    mmio_uart_bridge_tx_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_tx_fifo (
        .clock      (clock),
        .reset      (reset),
        .i_push     (w_thr_write),
        .i_push_data(req_wdata[7:0]),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_empty    (w_empty),
        .o_full     (w_full),
        .o_dropped  (w_drop)
    );

    // An expired gap counter behaves like IDLE, so TX_GAP idle cycles separate consecutive chars.
    // NOTE: default assigned first so no path through the case leaves it unassigned (no latch).
    always_comb begin
        w_drain_ready = 1'b0;
        case (r_state)
            ST_IDLE: w_drain_ready = 1'b1;
            ST_SEND: w_drain_ready = (TX_GAP == 0);
            ST_GAP:  w_drain_ready = (r_gap_cnt == '0);
            default: w_drain_ready = 1'b1;
        endcase
    end

    assign w_pop = w_drain_ready & ~w_empty;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_gap_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_out_ch    <= 8'h00;
        end else if (w_pop) begin
            r_out_valid <= 1'b1;
            r_out_ch    <= w_head;
            r_state     <= ST_SEND;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                ST_SEND: begin
                    if (TX_GAP == 0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= GAP_W'(TX_GAP - 1);
                        r_state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt != '0) r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                    else                 r_state   <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // A dropped push on the same edge as an LSR read keeps the flag set.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (w_lsr_read) begin
            r_overflow <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_rsp_rdata <= '0;
        end else if (w_load) begin
            r_rsp_rdata <= '0;
            if (w_lane == RBR_LANE) begin
                r_rsp_rdata[RBR_LSB +: 8] <= io_uart_in_ch;
            end else if (w_lane == LSR_LANE) begin
                r_rsp_rdata[LSR_LSB +: 8] <= lsr_byte(r_overflow, w_full);
            end
        end
    end

endmodule

// File: tb/tb_mmio_uart_bridge.sv
// Bench for mmio_uart_bridge: three instances (TX_GAP 0/2/3) share stimulus and are each compared
// against a queue-based timing model, plus a decode table and directed corner sequences.
module tb_mmio_uart_bridge;
    localparam logic [63:0] BASE      = 64'h1000_0000;
    localparam logic [60:0] BASE_WORD = BASE[63:3];
    localparam int          DEPTH     = 8;
    localparam int          N_INST    = 3;

    function automatic int gap_of(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 2 : 3);
    endfunction

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_wen;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [63:0] req_wmask;
    logic [7:0]  io_uart_in_ch;

    logic        hit       [N_INST];
    logic [63:0] rsp_rdata [N_INST];
    logic        out_valid [N_INST];
    logic [7:0]  out_ch    [N_INST];
    logic        in_valid  [N_INST];

    for (genvar gi = 0; gi < N_INST; gi++) begin : g_dut
        mmio_uart_bridge #(
            .UART_BASE (BASE),
            .FIFO_DEPTH(DEPTH),
            .TX_GAP    (gap_of(gi))
        ) u_dut (
            .clock            (clock),
            .reset            (reset),
            .req_valid        (req_valid),
            .req_wen          (req_wen),
            .req_addr         (req_addr),
            .req_wdata        (req_wdata),
            .req_wmask        (req_wmask),
            .hit              (hit[gi]),
            .rsp_rdata        (rsp_rdata[gi]),
            .io_uart_out_valid(out_valid[gi]),
            .io_uart_out_ch   (out_ch[gi]),
            .io_uart_in_valid (in_valid[gi]),
            .io_uart_in_ch    (io_uart_in_ch)
        );
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: pending chars, last pop edge, sticky overflow, expected outputs.
    logic [7:0]  mq       [N_INST][$];
    int          last_pop [N_INST];
    logic        m_ovf    [N_INST];
    logic [63:0] m_rd     [N_INST];
    logic        m_valid  [N_INST];
    logic [7:0]  m_ch     [N_INST];
    logic [7:0]  seen_ch  [N_INST][$];
    int          seen_cyc [N_INST][$];
    int          cyc;
    int          n_pass;
    int          n_checks;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        logic [2:0] lane;
        logic       in_win;
        logic       ld;
        logic       thr;
        logic       pop;
        logic       ok;
        lane   = req_addr[2:0];
        in_win = req_valid && (req_addr[63:3] == BASE_WORD);
        ld     = in_win && !req_wen;
        thr    = in_win && req_wen && (lane == 3'd0) && (req_wmask[7:0] == 8'hFF);
        for (int i = 0; i < N_INST; i++) begin
            if (!reset) begin
                mq[i].delete();
                last_pop[i] = -1000;
                m_ovf[i]    = 1'b0;
                m_rd[i]     = '0;
                m_valid[i]  = 1'b0;
                m_ch[i]     = 8'h00;
            end else begin
                pop = (mq[i].size() > 0) && ((cyc - last_pop[i]) > gap_of(i));
                if (ld) begin
                    m_rd[i] = '0;
                    if (lane == 3'd0) m_rd[i][7:0] = io_uart_in_ch;
                    else if (lane == 3'd5)
                        m_rd[i][47:40] = {m_ovf[i], 1'b0, (mq[i].size() != DEPTH), 4'b0000, 1'b1};
                end
                ok         = (mq[i].size() < DEPTH) || pop;
                m_valid[i] = pop;
                if (pop) begin
                    m_ch[i]     = mq[i].pop_front();
                    last_pop[i] = cyc;
                end
                if (thr) begin
                    if (ok) mq[i].push_back(req_wdata[7:0]);
                    else    m_ovf[i] = 1'b1;
                end else if (ld && (lane == 3'd5)) begin
                    m_ovf[i] = 1'b0;
                end
            end
        end
    endtask

    // One clock: check decode before the edge, advance the model, check registered outputs after.
    task automatic tick();
        logic exp_hit;
        logic exp_inv;
        #1;
        exp_hit = req_valid && (req_addr[63:3] == BASE_WORD);
        exp_inv = exp_hit && !req_wen && (req_addr[2:0] == 3'd0);
        for (int i = 0; i < N_INST; i++) begin
            check($sformatf("hit[%0d]", i), 64'(hit[i]), 64'(exp_hit));
            check($sformatf("in_valid[%0d]", i), 64'(in_valid[i]), 64'(exp_inv));
        end
        @(posedge clock);
        model_step();
        cyc++;
        #1;
        for (int i = 0; i < N_INST; i++) begin
            check($sformatf("out_valid[%0d]", i), 64'(out_valid[i]), 64'(m_valid[i]));
            if (m_valid[i]) check($sformatf("out_ch[%0d]", i), 64'(out_ch[i]), 64'(m_ch[i]));
            check($sformatf("rsp_rdata[%0d]", i), rsp_rdata[i], m_rd[i]);
            if (out_valid[i]) begin
                seen_ch[i].push_back(out_ch[i]);
                seen_cyc[i].push_back(cyc);
            end
        end
    endtask

    task automatic drive(input logic vld, input logic wen, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [63:0] wmask, input logic [7:0] in_ch);
        req_valid     = vld;
        req_wen       = wen;
        req_addr      = addr;
        req_wdata     = wdata;
        req_wmask     = wmask;
        io_uart_in_ch = in_ch;
    endtask

    task automatic store(input logic [63:0] addr, input logic [7:0] ch);
        drive(1'b1, 1'b1, addr, {56'h0, ch}, 64'hFF, 8'hFF);
        tick();
    endtask

    task automatic load(input logic [63:0] addr, input logic [7:0] in_ch);
        drive(1'b1, 1'b0, addr, 64'h0, 64'h0, in_ch);
        tick();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            drive(1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 8'hFF);
            tick();
        end
    endtask

    task automatic clear_seen();
        for (int i = 0; i < N_INST; i++) begin
            seen_ch[i].delete();
            seen_cyc[i].delete();
        end
    endtask

    typedef struct {
        logic        vld;
        logic        wen;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] wmask;
        logic [7:0]  in_ch;
        logic        exp_hit;
        logic        exp_inv;
        logic [63:0] exp_rd;
        logic        exp_ov;
        logic [7:0]  exp_ch;
    } vec_t;

    vec_t vecs [12];

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    initial begin
        logic [7:0] exp_c;
        n_pass   = 0;
        n_checks = 0;
        cyc      = 0;
        for (int i = 0; i < N_INST; i++) last_pop[i] = -1000;

        // Reset state.
        reset = 1'b0;
        idle(2);
        for (int i = 0; i < N_INST; i++) begin
            check($sformatf("reset out_valid[%0d]", i), 64'(out_valid[i]), 64'd0);
            check($sformatf("reset out_ch[%0d]", i), 64'(out_ch[i]), 64'd0);
            check($sformatf("reset rsp_rdata[%0d]", i), rsp_rdata[i], 64'd0);
        end
        reset = 1'b1;

        // Decode / load / store table; rows run in order so held rdata values are known.
        vecs[0]  = '{1'b1, 1'b0, BASE,                  64'h0,    64'h0,    8'h7A, 1'b1, 1'b1, 64'h7A,                  1'b0, 8'h00};
        vecs[1]  = '{1'b1, 1'b0, BASE + 64'd5,          64'h0,    64'h0,    8'h00, 1'b1, 1'b0, 64'h0000_2100_0000_0000, 1'b0, 8'h00};
        vecs[2]  = '{1'b1, 1'b0, BASE + 64'd8,          64'h0,    64'h0,    8'h11, 1'b0, 1'b0, 64'h0000_2100_0000_0000, 1'b0, 8'h00};
        vecs[3]  = '{1'b1, 1'b0, BASE - 64'd8,          64'h0,    64'h0,    8'h22, 1'b0, 1'b0, 64'h0000_2100_0000_0000, 1'b0, 8'h00};
        vecs[4]  = '{1'b1, 1'b0, BASE + 64'd7,          64'h0,    64'h0,    8'h33, 1'b1, 1'b0, 64'h0,                   1'b0, 8'h00};
        vecs[5]  = '{1'b0, 1'b0, BASE,                  64'h0,    64'h0,    8'h55, 1'b0, 1'b0, 64'h0,                   1'b0, 8'h00};
        vecs[6]  = '{1'b1, 1'b0, BASE | 64'h1_0000_0000, 64'h0,   64'h0,    8'h66, 1'b0, 1'b0, 64'h0,                   1'b0, 8'h00};
        vecs[7]  = '{1'b1, 1'b1, BASE + 64'd1,          64'h4200, 64'hFF00, 8'h00, 1'b1, 1'b0, 64'h0,                   1'b0, 8'h00};
        vecs[8]  = '{1'b1, 1'b1, BASE,                  64'h43,   64'h0F,   8'h00, 1'b1, 1'b0, 64'h0,                   1'b0, 8'h00};
        vecs[9]  = '{1'b1, 1'b1, BASE,                  64'h41,   64'hFF,   8'h00, 1'b1, 1'b0, 64'h0,                   1'b0, 8'h00};
        vecs[10] = '{1'b1, 1'b0, BASE,                  64'h0,    64'h0,    8'hFF, 1'b1, 1'b1, 64'hFF,                  1'b1, 8'h41};
        vecs[11] = '{1'b0, 1'b0, 64'h0,                 64'h0,    64'h0,    8'h00, 1'b0, 1'b0, 64'hFF,                  1'b0, 8'h00};
        for (int k = 0; k < 12; k++) begin
            drive(vecs[k].vld, vecs[k].wen, vecs[k].addr, vecs[k].wdata, vecs[k].wmask, vecs[k].in_ch);
            #1;
            check($sformatf("vec%0d hit", k), 64'(hit[0]), 64'(vecs[k].exp_hit));
            check($sformatf("vec%0d in_valid", k), 64'(in_valid[0]), 64'(vecs[k].exp_inv));
            tick();
            for (int i = 0; i < N_INST; i++) begin
                check($sformatf("vec%0d rdata[%0d]", k, i), rsp_rdata[i], vecs[k].exp_rd);
                check($sformatf("vec%0d out_valid[%0d]", k, i), 64'(out_valid[i]), 64'(vecs[k].exp_ov));
                if (vecs[k].exp_ov) check($sformatf("vec%0d out_ch[%0d]", k, i), 64'(out_ch[i]), 64'(vecs[k].exp_ch));
            end
        end

        // Back-to-back 'H','i','!': consecutive with no gap, three cycles apart with TX_GAP=2.
        clear_seen();
        store(BASE, 8'h48);
        store(BASE, 8'h69);
        store(BASE, 8'h21);
        idle(12);
        check("hi! count gap0", 64'(seen_ch[0].size()), 64'd3);
        check("hi! count gap2", 64'(seen_ch[1].size()), 64'd3);
        if (seen_ch[0].size() == 3) begin
            check("hi! ch0", 64'(seen_ch[0][0]), 64'h48);
            check("hi! ch1", 64'(seen_ch[0][1]), 64'h69);
            check("hi! ch2", 64'(seen_ch[0][2]), 64'h21);
            check("gap0 spacing a", 64'(seen_cyc[0][1] - seen_cyc[0][0]), 64'd1);
            check("gap0 spacing b", 64'(seen_cyc[0][2] - seen_cyc[0][1]), 64'd1);
        end
        if (seen_ch[1].size() == 3) begin
            check("gap2 spacing a", 64'(seen_cyc[1][1] - seen_cyc[1][0]), 64'd3);
            check("gap2 spacing b", 64'(seen_cyc[1][2] - seen_cyc[1][1]), 64'd3);
        end

        // Overflow with TX_GAP=3: 15 stores, drops on the full-without-pop edges, LSR clear-on-read.
        reset = 1'b0;
        idle(1);
        reset = 1'b1;
        clear_seen();
        for (int k = 0; k < 15; k++) store(BASE, 8'(8'h60 + k));
        load(BASE + 64'd5, 8'h00);
        check("lsr ovf set gap3", rsp_rdata[2], 64'h0000_8100_0000_0000);
        load(BASE + 64'd5, 8'h00);
        check("lsr ovf cleared gap3", rsp_rdata[2], 64'h0000_0100_0000_0000);
        idle(60);
        check("ovf accepted count gap3", 64'(seen_ch[2].size()), 64'd12);
        if (seen_ch[2].size() == 12) begin
            for (int k = 0; k < 12; k++) begin
                exp_c = (k < 11) ? 8'(8'h60 + k) : 8'h6D;
                check($sformatf("ovf order %0d", k), 64'(seen_ch[2][k]), 64'(exp_c));
            end
        end
        load(BASE + 64'd5, 8'h00);
        check("lsr drained gap3", rsp_rdata[2], 64'h0000_2100_0000_0000);

        // Reset with four chars queued and one in flight: nothing comes out afterwards.
        for (int k = 0; k < 6; k++) store(BASE, 8'(8'h30 + k));
        check("in flight before reset", 64'(out_valid[2]), 64'd1);
        reset = 1'b0;
        clear_seen();
        idle(1);
        for (int i = 0; i < N_INST; i++)
            check($sformatf("reset mid-char out_valid[%0d]", i), 64'(out_valid[i]), 64'd0);
        reset = 1'b1;
        idle(20);
        for (int i = 0; i < N_INST; i++)
            check($sformatf("no chars after reset[%0d]", i), 64'(seen_ch[i].size()), 64'd0);

        // Randomized traffic: store-heavy first half to push FIFOs into overflow, then mixed.
        for (int t = 0; t < 600; t++) begin
            reset     = ($urandom_range(0, 99) != 0);
            req_valid = ($urandom_range(0, 3) != 0);
            req_wen   = (t < 300) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 7))
                0:       req_addr = {$urandom, $urandom};
                1:       req_addr = ($urandom_range(0, 1) == 1) ? BASE + 64'($urandom_range(8, 15))
                                                                : BASE - 64'($urandom_range(1, 8));
                2:       req_addr = BASE + 64'd5;
                3:       req_addr = BASE + 64'($urandom_range(0, 7));
                default: req_addr = BASE;
            endcase
            req_wdata     = {$urandom, $urandom};
            req_wmask     = ($urandom_range(0, 7) != 0) ? 64'hFF : {$urandom, $urandom};
            io_uart_in_ch = 8'($urandom_range(0, 255));
            tick();
        end
        reset = 1'b1;
        idle(40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
